// File: rtl/bunch_timing_gen.sv
// bunch_timing_gen: sample-counter driven bunch window strobes and delayed LUT match pulses.
// Build option: define TIMING_CFG_CHECK_EN to add configuration checking (cfg_err).
module bunch_timing_gen #(
    parameter int CNT_W   = 8,
    parameter int NB_W    = 2,
    parameter int NS_W    = 4,
    parameter int LUT_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             store_strb,
    input  logic [CNT_W-1:0] b1_strobe,
    input  logic [CNT_W-1:0] b2_strobe,
    input  logic [NB_W-1:0]  no_bunches,
    input  logic [NS_W-1:0]  no_samples,
    input  logic [CNT_W-1:0] sample_spacing,
    output logic             bunch_strb,
    output logic             LUTcond,
    output logic [NB_W-1:0]  bunch_idx,
    output logic             done,
    output logic             cfg_err
);
    // state | meaning
    // IDLE  | store_strb low (or not yet armed), counter cleared, config tracking inputs
    // GAP   | acquiring, waiting for start of window k
    // WIN   | acquiring, inside window k
    // DONE  | all bunches finished or counter saturated inside a window
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GAP  = 2'd1;
    localparam logic [1:0] WIN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int W = CNT_W + NB_W + 1;
    localparam logic [CNT_W-1:0] I_MAX = '1;

    logic [1:0]         st, st_nxt;
    logic [CNT_W-1:0]   i_cnt;
    logic               armed, run, sat;
    logic [CNT_W-1:0]   b1_r, b2_r, sp_r;
    logic [NB_W-1:0]    nb_r, nb_eff;
    logic [NS_W-1:0]    ns_r;
    logic [NB_W-1:0]    k, k_nxt;
    logic [W-1:0]       off, off_nxt, i_w, s_k, e_k;
    logic               in_win, win_end, last_k, hit;
    logic [NB_W-1:0]    lut_cnt, lut_lim;
    logic [W-1:0]       lut_off, lut_pt;
    logic               lut_hit, sat_seen;
    logic [LUT_LAT-1:0] lut_pipe;

    // Nothing starts after reset until store_strb has been seen low once.
    assign run     = store_strb & armed;
    assign sat     = (i_cnt == I_MAX);
    assign i_w     = W'(i_cnt);
    assign s_k     = W'(b1_r) + off;
    assign e_k     = s_k + W'(ns_r);
    assign in_win  = (ns_r != '0) && (i_w >= s_k) && (i_w < e_k);
    assign win_end = (ns_r == '0) ? (i_w >= s_k) : ((i_w + W'(1)) >= e_k);
    assign last_k  = (k == (nb_eff - NB_W'(1)));
    assign hit     = run && in_win && !sat &&
                     ((st == GAP) || (st == WIN) || ((st == IDLE) && (nb_r != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            i_cnt <= '0;
            b1_r  <= '0;
            b2_r  <= '0;
            sp_r  <= '0;
            nb_r  <= '0;
            ns_r  <= '0;
        end else begin
            if (!store_strb) begin
                armed <= 1'b1;
                b1_r  <= b1_strobe;
                b2_r  <= b2_strobe;
                sp_r  <= sample_spacing;
                nb_r  <= no_bunches;
                ns_r  <= no_samples;
            end
            if (!run) begin
                i_cnt <= '0;
            end else if (!sat) begin
                i_cnt <= i_cnt + CNT_W'(1);
            end
        end
    end

    // Comparisons use >= so overlapping or coincident windows advance k without stalling.
    always_comb begin
        st_nxt  = st;
        k_nxt   = k;
        off_nxt = off;
        if (!run) begin
            st_nxt  = IDLE;
            k_nxt   = '0;
            off_nxt = '0;
        end else begin
            case (st)
                IDLE, GAP, WIN: begin
                    if ((st == IDLE) && (nb_r == '0)) begin
                        st_nxt = DONE;
                    end else if (sat) begin
                        if (st == WIN) st_nxt = DONE;
                    end else if (win_end) begin
                        if (last_k) begin
                            st_nxt = DONE;
                        end else begin
                            st_nxt  = GAP;
                            k_nxt   = k + NB_W'(1);
                            off_nxt = off + W'(sp_r);
                        end
                    end else if (in_win) begin
                        st_nxt = WIN;
                    end else begin
                        st_nxt = GAP;
                    end
                end
                default: st_nxt = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            k          <= '0;
            off        <= '0;
            bunch_strb <= 1'b0;
            bunch_idx  <= '0;
        end else begin
            st         <= st_nxt;
            k          <= k_nxt;
            off        <= off_nxt;
            bunch_strb <= hit;
            if (!run) begin
                bunch_idx <= '0;
            end else if (hit) begin
                bunch_idx <= k;
            end
        end
    end

    assign done = (st == DONE);

    // LUT match points run independently of the window FSM; sat_seen stops a held
    // saturated counter from re-matching coincident points.
    assign lut_lim = (nb_r == '0) ? NB_W'(1) : nb_r;
    assign lut_pt  = W'(b2_r) + lut_off;
    assign lut_hit = run && !sat_seen && (lut_cnt < lut_lim) && (i_w == lut_pt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_cnt  <= '0;
            lut_off  <= '0;
            sat_seen <= 1'b0;
            lut_pipe <= '0;
        end else begin
            sat_seen <= run & sat;
            if (!run) begin
                lut_cnt <= '0;
                lut_off <= '0;
            end else if (lut_hit) begin
                lut_cnt <= lut_cnt + NB_W'(1);
                lut_off <= lut_off + W'(sp_r);
            end
            lut_pipe[0] <= lut_hit;
            for (int j = 1; j < LUT_LAT; j++) begin
                lut_pipe[j] <= lut_pipe[j-1];
            end
        end
    end

    assign LUTcond = lut_pipe[LUT_LAT-1];

`ifdef TIMING_CFG_CHECK_EN
    logic cfg_bad;

    // A bad configuration limits the run to bunch 0.
    assign cfg_bad = (nb_r > NB_W'(1)) && ((sp_r == '0) || (W'(ns_r) > W'(sp_r)));
    assign nb_eff  = cfg_bad ? NB_W'(1) : nb_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= store_strb & cfg_bad;
        end
    end
`else
    assign nb_eff  = nb_r;
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_bunch_timing_gen.sv
// tb_bunch_timing_gen: directed scenarios for bunch_timing_gen with hand-computed expectations.
// Sample n (negedge after the n-th edge with store_strb high) reflects counter value i=n.
module tb_bunch_timing_gen;
    localparam int CNT_W   = 8;
    localparam int NB_W    = 2;
    localparam int NS_W    = 4;
    localparam int LUT_LAT = 3;
    localparam int NCAP    = 300;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             store_strb = 1'b0;
    logic [CNT_W-1:0] b1_strobe = '0;
    logic [CNT_W-1:0] b2_strobe = '0;
    logic [NB_W-1:0]  no_bunches = '0;
    logic [NS_W-1:0]  no_samples = '0;
    logic [CNT_W-1:0] sample_spacing = '0;
    logic             bunch_strb, LUTcond, done, cfg_err;
    logic [NB_W-1:0]  bunch_idx;

    int checks = 0;
    int errors = 0;

    logic            cap_bs  [NCAP];
    logic            cap_lc  [NCAP];
    logic            cap_dn  [NCAP];
    logic [NB_W-1:0] cap_idx [NCAP];

    bunch_timing_gen #(
        .CNT_W(CNT_W), .NB_W(NB_W), .NS_W(NS_W), .LUT_LAT(LUT_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .store_strb(store_strb),
        .b1_strobe(b1_strobe), .b2_strobe(b2_strobe), .no_bunches(no_bunches),
        .no_samples(no_samples), .sample_spacing(sample_spacing),
        .bunch_strb(bunch_strb), .LUTcond(LUTcond), .bunch_idx(bunch_idx),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic configure(input int b1, input int b2, input int sp, input int nb, input int ns);
        @(negedge clk);
        store_strb     = 1'b0;
        b1_strobe      = CNT_W'(b1);
        b2_strobe      = CNT_W'(b2);
        sample_spacing = CNT_W'(sp);
        no_bunches     = NB_W'(nb);
        no_samples     = NS_W'(ns);
        repeat (2) @(negedge clk);
    endtask

    task automatic capture(input int n);
        store_strb = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            cap_bs[c]  = bunch_strb;
            cap_lc[c]  = LUTcond;
            cap_dn[c]  = done;
            cap_idx[c] = bunch_idx;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bunch_strb, LUTcond, done, cfg_err, bunch_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got bs=%0b lc=%0b dn=%0b err=%0b idx=%0d exp all 0",
                     bunch_strb, LUTcond, done, cfg_err, bunch_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bunch_strb, LUTcond, done, cfg_err, bunch_idx} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got bs=%0b lc=%0b dn=%0b idx=%0d exp all 0",
                     bunch_strb, LUTcond, done, bunch_idx);
        end
    endtask

    // b1=10 spacing=100 ns=4 nb=2 b2=20: windows 10..13 / 110..113, LUT at 22 / 122.
    task automatic test_basic(input string tag);
        logic e_bs, e_lc, e_dn;
        logic [NB_W-1:0] e_idx;
        configure(10, 20, 100, 2, 4);
        capture(130);
        for (int c = 0; c < 130; c++) begin
            e_bs  = ((c >= 10) && (c <= 13)) || ((c >= 110) && (c <= 113));
            e_lc  = (c == 22) || (c == 122);
            e_dn  = (c >= 113);
            e_idx = (c >= 110) ? NB_W'(1) : NB_W'(0);
            checks += 5;
            if (cap_bs[c] !== e_bs) begin errors++; $display("FAIL %s bunch_strb i=%0d got %0b exp %0b", tag, c, cap_bs[c], e_bs); end
            if (cap_lc[c] !== e_lc) begin errors++; $display("FAIL %s LUTcond i=%0d got %0b exp %0b", tag, c, cap_lc[c], e_lc); end
            if (cap_dn[c] !== e_dn) begin errors++; $display("FAIL %s done i=%0d got %0b exp %0b", tag, c, cap_dn[c], e_dn); end
            if (cap_idx[c] !== e_idx) begin errors++; $display("FAIL %s bunch_idx i=%0d got %0d exp %0d", tag, c, cap_idx[c], e_idx); end
            if (cfg_err !== 1'b0) begin errors++; $display("FAIL %s cfg_err got %0b exp 0", tag, cfg_err); end
        end
    endtask

    task automatic test_no_bunches;
        configure(10, 5, 100, 0, 4);
        capture(40);
        for (int c = 0; c < 40; c++) begin
            checks += 3;
            if (cap_bs[c] !== 1'b0) begin errors++; $display("FAIL nb0 bunch_strb i=%0d got %0b exp 0", c, cap_bs[c]); end
            if (cap_dn[c] !== 1'b1) begin errors++; $display("FAIL nb0 done i=%0d got %0b exp 1", c, cap_dn[c]); end
            if (cap_lc[c] !== (c == 7)) begin errors++; $display("FAIL nb0 LUTcond i=%0d got %0b exp %0b", c, cap_lc[c], (c == 7)); end
        end
    endtask

    task automatic test_saturation;
        configure(250, 200, 7, 1, 10);
        capture(270);
        for (int c = 0; c < 270; c++) begin
            checks += 3;
            if (cap_bs[c] !== ((c >= 250) && (c <= 254))) begin errors++; $display("FAIL sat bunch_strb i=%0d got %0b", c, cap_bs[c]); end
            if (cap_dn[c] !== (c >= 255)) begin errors++; $display("FAIL sat done i=%0d got %0b exp %0b", c, cap_dn[c], (c >= 255)); end
            if (cap_lc[c] !== (c == 202)) begin errors++; $display("FAIL sat LUTcond i=%0d got %0b exp %0b", c, cap_lc[c], (c == 202)); end
        end
    endtask

    // ns=0: starts 5, 15, 25 pass with no strobe; LUT points 3, 13, 23.
    task automatic test_empty_windows;
        configure(5, 3, 10, 3, 0);
        capture(40);
        for (int c = 0; c < 40; c++) begin
            checks += 3;
            if (cap_bs[c] !== 1'b0) begin errors++; $display("FAIL empty bunch_strb i=%0d got %0b exp 0", c, cap_bs[c]); end
            if (cap_dn[c] !== (c >= 25)) begin errors++; $display("FAIL empty done i=%0d got %0b exp %0b", c, cap_dn[c], (c >= 25)); end
            if (cap_lc[c] !== ((c == 5) || (c == 15) || (c == 25))) begin errors++; $display("FAIL empty LUTcond i=%0d got %0b", c, cap_lc[c]); end
        end
    endtask

    // Windows 10..13 and 12..15 merge into 10..15.
    task automatic test_merge;
        configure(10, 50, 2, 2, 4);
        capture(30);
        for (int c = 0; c < 30; c++) begin
            checks += 3;
            if (cap_bs[c] !== ((c >= 10) && (c <= 15))) begin errors++; $display("FAIL merge bunch_strb i=%0d got %0b", c, cap_bs[c]); end
            if (cap_dn[c] !== (c >= 15)) begin errors++; $display("FAIL merge done i=%0d got %0b exp %0b", c, cap_dn[c], (c >= 15)); end
            if (cap_idx[c] !== ((c >= 14) ? NB_W'(1) : NB_W'(0))) begin errors++; $display("FAIL merge bunch_idx i=%0d got %0d", c, cap_idx[c]); end
        end
    endtask

    // spacing=0, nb=3: three coincident LUT points at 7 give one pulse.
    task automatic test_lut_coincide;
        int pulses;
        configure(30, 7, 0, 3, 2);
        capture(45);
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            pulses += int'(cap_lc[c]);
            checks += 2;
            if (cap_lc[c] !== (c == 9)) begin errors++; $display("FAIL coincide LUTcond i=%0d got %0b exp %0b", c, cap_lc[c], (c == 9)); end
            if (cap_bs[c] !== ((c == 30) || (c == 31))) begin errors++; $display("FAIL coincide bunch_strb i=%0d got %0b", c, cap_bs[c]); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL coincide pulse_count got %0d exp 1", pulses); end
    endtask

    task automatic test_abort;
        configure(10, 11, 100, 2, 4);
        capture(12);
        checks++;
        if ((cap_bs[10] !== 1'b1) || (cap_bs[11] !== 1'b1)) begin
            errors++;
            $display("FAIL abort pre_window got %0b%0b exp 11", cap_bs[10], cap_bs[11]);
        end
        store_strb = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({bunch_strb, done, LUTcond, bunch_idx} !== '0) begin
            errors++;
            $display("FAIL abort next_cycle got bs=%0b dn=%0b lc=%0b idx=%0d exp all 0", bunch_strb, done, LUTcond, bunch_idx);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (LUTcond !== 1'b1) begin errors++; $display("FAIL abort pending_lut got %0b exp 1", LUTcond); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (LUTcond !== 1'b0) begin errors++; $display("FAIL abort lut_single got %0b exp 0", LUTcond); end
        test_basic("restart");
    endtask

    task automatic test_reset_mid;
        configure(10, 10, 100, 2, 4);
        capture(12);
        checks++;
        if (cap_bs[11] !== 1'b1) begin errors++; $display("FAIL rst_mid in_window got %0b exp 1", cap_bs[11]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bunch_strb, LUTcond, done, bunch_idx} !== '0) begin
            errors++;
            $display("FAIL rst_mid async got bs=%0b lc=%0b dn=%0b idx=%0d exp all 0", bunch_strb, LUTcond, done, bunch_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({bunch_strb, LUTcond, done} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid held_store c=%0d got bs=%0b lc=%0b dn=%0b exp 000", c, bunch_strb, LUTcond, done);
            end
        end
        test_basic("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_no_bunches();
        test_saturation();
        test_empty_windows();
        test_merge();
        test_lut_coincide();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
